epcq_update_sequencer: RTL and testbench

//  Command sequencer for the EPCQ serial-flash IO block used by remote firmware update.

---
 rtl/epcq_seq_pkg.sv | 38 +++
 rtl/epcq_page_buffer.sv | 47 ++++
 rtl/epcq_update_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_epcq_update_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/epcq_seq_pkg.sv
// Shared types and constants for the EPCQ update command sequencer.
package epcq_seq_pkg;

  localparam int PAGE_DEPTH = 256;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_CHECK     = 4'd1;
  localparam logic [3:0] ST_ERASE     = 4'd2;
  localparam logic [3:0] ST_SHIFT     = 4'd3;
  localparam logic [3:0] ST_WRITE     = 4'd4;
  localparam logic [3:0] ST_READ      = 4'd5;
  localparam logic [3:0] ST_RDWAIT    = 4'd6;
  localparam logic [3:0] ST_WAIT_BUSY = 4'd7;
  localparam logic [3:0] ST_FIN       = 4'd8;

  typedef enum logic [1:0] {
    OP_ILLEGAL = 2'b00,
    OP_ERASE   = 2'b01,
    OP_PROGRAM = 2'b10,
    OP_READ    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ERR_OK        = 3'd0,
    ERR_BAD_CMD   = 3'd1,
    ERR_PAGE_CROSS = 3'd2,
    ERR_ILL_ERASE = 3'd3,
    ERR_ILL_WRITE = 3'd4,
    ERR_TIMEOUT   = 3'd5
  } err_e;

  // True when a program of len bytes starting at page offset offs would spill into the next page.
  function automatic logic page_cross(input logic [7:0] offs, input logic [8:0] len,
                                      input logic [8:0] page_max);
    return ({2'b00, offs} + {1'b0, len}) > {1'b0, page_max};
  endfunction

endpackage

// File: rtl/epcq_page_buffer.sv
// Page buffer: simple dual-port RAM with one write port and one registered read port.
module epcq_page_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;
  logic [7:0] rd_data_d;

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read-data next value: only updates on a read so the last byte is held.
  always_comb begin
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Read-data register, cleared on reset so the flash datain bus idles at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/epcq_update_sequencer.sv
// Sequences erase/program/read commands onto the EPCQ flash IO block strobes.
module epcq_update_sequencer
  import epcq_seq_pkg::*;
#(
  parameter int PAGE_BYTES     = PAGE_DEPTH,
  parameter int TIMEOUT_CYCLES = 33554432,
  parameter int TO_W           = 26
) (
  input  logic        clkin,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [8:0]  cmd_len,
  input  logic        buf_wr_en,
  input  logic [7:0]  buf_wr_addr,
  input  logic [7:0]  buf_wr_data,
  output logic [7:0]  rd_data,
  output logic        rd_data_valid,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [23:0] epcq_addr,
  output logic [7:0]  epcq_datain,
  output logic        epcq_shift_bytes,
  output logic        epcq_wren,
  output logic        epcq_write,
  output logic        epcq_sector_erase,
  output logic        epcq_bulk_erase,
  output logic        epcq_read,
  output logic        epcq_rden,
  output logic        epcq_reset,
  input  logic        epcq_busy,
  input  logic        epcq_data_valid,
  input  logic [7:0]  epcq_dataout,
  input  logic        epcq_illegal_erase,
  input  logic        epcq_illegal_write
);

  localparam logic [8:0]      LEN_MAX = 9'(PAGE_BYTES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};

  logic [3:0]      state_q, state_d;
  op_e             op_q, op_d;
  logic [23:0]     addr_q, addr_d;
  logic [8:0]      len_q, len_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  err_e            code_q, code_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [23:0] epcq_addr_q, epcq_addr_d;
  logic        wren_q, wren_d, shift_q, shift_d, write_q, write_d;
  logic        erase_q, erase_d, read_q, read_d, rden_q, rden_d, fl_reset_q, fl_reset_d;

  logic        accept_s;
  logic        buf_rd_en_s;
  logic [7:0]  buf_rd_addr_s;

  assign accept_s = (state_q == ST_IDLE) && cmd_valid;

  // Command FSM and its bookkeeping counters.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    code_d     = code_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    fl_reset_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          code_d  = ERR_OK;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
        cnt_d = 9'd0;
        to_d  = TO_ZERO;
      end
      ST_CHECK: begin
        if ((op_q == OP_ILLEGAL) ||
            ((op_q != OP_ERASE) && ((len_q == 9'd0) || (len_q > LEN_MAX)))) begin
          code_d  = ERR_BAD_CMD;
          state_d = ST_FIN;
        end else if ((op_q == OP_PROGRAM) && page_cross(addr_q[7:0], len_q, LEN_MAX)) begin
          code_d  = ERR_PAGE_CROSS;
          state_d = ST_FIN;
        end else if (op_q == OP_ERASE) begin
          state_d = ST_ERASE;
        end else if (op_q == OP_PROGRAM) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_ERASE:  state_d = ST_WAIT_BUSY;
      ST_SHIFT: begin
        if (cnt_q == (len_q - 9'd1)) begin
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_WRITE:  state_d = ST_WAIT_BUSY;
      ST_READ: begin
        cnt_d   = 9'd0;
        state_d = ST_RDWAIT;
      end
      ST_RDWAIT: begin
        if (epcq_data_valid && (cnt_q < len_q)) begin
          rd_valid_d = 1'b1;
          rd_data_d  = epcq_dataout;
          cnt_d      = cnt_q + 9'd1;
          if ((cnt_q + 9'd1) == len_q) begin
            state_d = ST_WAIT_BUSY;
          end else begin
            state_d = ST_RDWAIT;
          end
        end else begin
          state_d = ST_RDWAIT;
        end
      end
      ST_WAIT_BUSY: begin
        to_d = to_q + TO_ONE;
        if ((code_q == ERR_OK) && epcq_illegal_erase) begin
          code_d = ERR_ILL_ERASE;
        end else if ((code_q == ERR_OK) && epcq_illegal_write) begin
          code_d = ERR_ILL_WRITE;
        end else begin
          code_d = code_q;
        end
        // The first cycle is skipped: the IO block needs a cycle to raise busy.
        if (to_q == TO_LAST) begin
          code_d     = ERR_TIMEOUT;
          fl_reset_d = 1'b1;
          state_d    = ST_FIN;
        end else if ((to_q != TO_ZERO) && !epcq_busy) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output strobes decoded from the next state so every output comes straight from a flop.
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    wren_d      = (state_d == ST_ERASE) || (state_d == ST_SHIFT) || (state_d == ST_WRITE);
    erase_d     = (state_d == ST_ERASE);
    shift_d     = (state_d == ST_SHIFT);
    write_d     = (state_d == ST_WRITE);
    read_d      = (state_d == ST_READ);
    rden_d      = (state_d == ST_READ) || (state_d == ST_RDWAIT);
    done_d      = (state_d == ST_FIN);
    if ((state_d == ST_IDLE) || (state_d == ST_CHECK) || (state_d == ST_FIN)) begin
      epcq_addr_d = 24'h000000;
    end else begin
      epcq_addr_d = addr_q;
    end
    if (state_d == ST_FIN) begin
      err_d      = (code_d != ERR_OK);
      err_code_d = code_d;
    end else if (accept_s) begin
      err_d      = 1'b0;
      err_code_d = 3'd0;
    end else begin
      err_d      = err_q;
      err_code_d = err_code_q;
    end
    buf_rd_en_s   = (state_d == ST_SHIFT);
    buf_rd_addr_s = addr_q[7:0] + cnt_d[7:0];
  end

  // State, command context and registered outputs.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ILLEGAL;
      addr_q      <= 24'h000000;
      len_q       <= 9'd0;
      cnt_q       <= 9'd0;
      to_q        <= TO_ZERO;
      code_q      <= ERR_OK;
      cmd_ready_q <= 1'b1;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
      epcq_addr_q <= 24'h000000;
      wren_q      <= 1'b0;
      shift_q     <= 1'b0;
      write_q     <= 1'b0;
      erase_q     <= 1'b0;
      read_q      <= 1'b0;
      rden_q      <= 1'b0;
      fl_reset_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      code_q      <= code_d;
      cmd_ready_q <= cmd_ready_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      epcq_addr_q <= epcq_addr_d;
      wren_q      <= wren_d;
      shift_q     <= shift_d;
      write_q     <= write_d;
      erase_q     <= erase_d;
      read_q      <= read_d;
      rden_q      <= rden_d;
      fl_reset_q  <= fl_reset_d;
    end
  end

  epcq_page_buffer #(
    .DEPTH (PAGE_BYTES),
    .AW    (8)
  ) u_page_buffer (
    .clk     (clkin),
    .rst_n   (reset_n),
    .wr_en   (buf_wr_en && (state_q == ST_IDLE)),
    .wr_addr (buf_wr_addr),
    .wr_data (buf_wr_data),
    .rd_en   (buf_rd_en_s),
    .rd_addr (buf_rd_addr_s),
    .rd_data (epcq_datain)
  );

  assign cmd_ready         = cmd_ready_q;
  assign rd_data           = rd_data_q;
  assign rd_data_valid     = rd_valid_q;
  assign done              = done_q;
  assign err               = err_q;
  assign err_code          = err_code_q;
  assign epcq_addr         = epcq_addr_q;
  assign epcq_shift_bytes  = shift_q;
  assign epcq_wren         = wren_q;
  assign epcq_write        = write_q;
  assign epcq_sector_erase = erase_q;
  assign epcq_bulk_erase   = 1'b0;
  assign epcq_read         = read_q;
  assign epcq_rden         = rden_q;
  assign epcq_reset        = fl_reset_q;

endmodule

// File: tb/tb_epcq_update_sequencer.sv
// Directed bench for epcq_update_sequencer with a behavioural EPCQ IO-block model.
module tb_epcq_update_sequencer;

  logic        clkin = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [23:0] cmd_addr = 24'h000000;
  logic [8:0]  cmd_len = 9'd0;
  logic        buf_wr_en = 1'b0;
  logic [7:0]  buf_wr_addr = 8'h00;
  logic [7:0]  buf_wr_data = 8'h00;
  logic [7:0]  rd_data;
  logic        rd_data_valid, done, err;
  logic [2:0]  err_code;
  logic [23:0] epcq_addr;
  logic [7:0]  epcq_datain;
  logic        epcq_shift_bytes, epcq_wren, epcq_write, epcq_sector_erase, epcq_bulk_erase;
  logic        epcq_read, epcq_rden, epcq_reset;
  logic        epcq_busy = 1'b0;
  logic        epcq_data_valid = 1'b0;
  logic [7:0]  epcq_dataout = 8'h00;
  logic        epcq_illegal_erase = 1'b0;
  logic        epcq_illegal_write = 1'b0;

  always #5 clkin = ~clkin;

  epcq_update_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clkin(clkin), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .done(done), .err(err), .err_code(err_code),
    .epcq_addr(epcq_addr), .epcq_datain(epcq_datain), .epcq_shift_bytes(epcq_shift_bytes),
    .epcq_wren(epcq_wren), .epcq_write(epcq_write), .epcq_sector_erase(epcq_sector_erase),
    .epcq_bulk_erase(epcq_bulk_erase), .epcq_read(epcq_read), .epcq_rden(epcq_rden),
    .epcq_reset(epcq_reset), .epcq_busy(epcq_busy), .epcq_data_valid(epcq_data_valid),
    .epcq_dataout(epcq_dataout), .epcq_illegal_erase(epcq_illegal_erase),
    .epcq_illegal_write(epcq_illegal_write)
  );

  // Controls from the stimulus process to the IO-block model.
  bit clr_req = 1'b0;
  bit m_hang  = 1'b0;
  bit m_illw  = 1'b0;

  // Model state and observation counters (owned by the model process).
  int          n_wren, n_erase, n_write, n_shift, n_read, n_rden, n_reset, n_done, n_rdv;
  int          n_data_err, n_rd_err;
  logic [23:0] erase_addr, write_addr;
  logic [7:0]  first_shift;
  logic        rden_at_last;
  int          m_busy_cnt, m_tick, m_rptr;
  bit          m_stuck, m_reading;
  logic [7:0]  shq[$];
  logic [7:0]  flash_mem [int];

  // Behavioural IO block: busy 20 cycles after erase/write, read data every 4 cycles.
  always @(posedge clkin) begin
    if (clr_req) begin
      n_wren = 0; n_erase = 0; n_write = 0; n_shift = 0; n_read = 0; n_rden = 0;
      n_reset = 0; n_done = 0; n_rdv = 0; n_data_err = 0; n_rd_err = 0;
      erase_addr = 24'h0; write_addr = 24'h0; first_shift = 8'h00; rden_at_last = 1'b1;
    end
    if (!reset_n) begin
      m_busy_cnt = 0; m_tick = 0; m_stuck = 1'b0; m_reading = 1'b0;
      shq.delete();
      epcq_busy <= 1'b0; epcq_data_valid <= 1'b0; epcq_illegal_write <= 1'b0;
    end else begin
      epcq_data_valid    <= 1'b0;
      epcq_illegal_write <= 1'b0;
      if (m_busy_cnt > 0) m_busy_cnt--;
      if (m_busy_cnt == 10 && m_illw) epcq_illegal_write <= 1'b1;
      if (epcq_wren) n_wren++;
      if (epcq_rden) n_rden++;
      if (epcq_shift_bytes) begin
        if (n_shift == 0) first_shift = epcq_datain;
        if (epcq_datain !== ((epcq_addr[7:0] + 8'(n_shift)) ^ 8'hA5)) n_data_err++;
        shq.push_back(epcq_datain);
        n_shift++;
      end
      if (epcq_write) begin
        n_write++;
        write_addr = epcq_addr;
        foreach (shq[i]) flash_mem[int'(epcq_addr) + i] = shq[i];
        shq.delete();
        m_busy_cnt = 20;
        if (m_hang) m_stuck = 1'b1;
      end
      if (epcq_sector_erase) begin
        n_erase++;
        erase_addr = epcq_addr;
        m_busy_cnt = 20;
        if (m_hang) m_stuck = 1'b1;
      end
      if (epcq_read) begin
        n_read++;
        m_reading = 1'b1;
        m_tick = 0;
        m_rptr = int'(epcq_addr);
      end else if (m_reading) begin
        if (!epcq_rden) begin
          m_reading = 1'b0;
        end else begin
          m_tick++;
          if (m_tick % 4 == 0) begin
            epcq_data_valid <= 1'b1;
            epcq_dataout    <= flash_mem.exists(m_rptr) ? flash_mem[m_rptr] : 8'hFF;
            m_rptr++;
          end
        end
      end
      if (epcq_reset) begin
        n_reset++;
        m_busy_cnt = 0;
        m_stuck = 1'b0;
      end
      if (done) n_done++;
      if (rd_data_valid) begin
        if (rd_data !== (8'(n_rdv) ^ 8'hA5)) n_rd_err++;
        if (n_rdv == 15) rden_at_last = epcq_rden;
        n_rdv++;
      end
      epcq_busy <= (m_busy_cnt > 0) || m_stuck || m_reading;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    @(negedge clkin) clr_req = 1'b1;
    @(negedge clkin) clr_req = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [23:0] addr, input logic [8:0] len,
                          input bit poke);
    bit rdy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clkin);
      if (cmd_ready) begin
        rdy = 1'b1;
        break;
      end
    end
    check_eq("ready_before_cmd", {31'd0, rdy}, 32'd1);
    cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    @(negedge clkin);
    cmd_valid = 1'b0;
    check_eq("ready_low_after_accept", {31'd0, cmd_ready}, 32'd0);
    check_eq("err_cleared_on_accept", {31'd0, err}, 32'd0);
    if (poke) begin
      buf_wr_en = 1'b1; buf_wr_addr = 8'h00; buf_wr_data = 8'h00;
      @(negedge clkin);
      buf_wr_en = 1'b0;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [23:0] addr, input logic [8:0] len,
                         input bit poke, input logic [2:0] exp_code);
    bit         seen = 1'b0;
    logic       e = 1'b0;
    logic [2:0] c = 3'd0;
    clear_counts();
    send_cmd(op, addr, len, poke);
    for (int i = 0; i < 1000; i++) begin
      if (done) begin
        seen = 1'b1;
        e = err;
        c = err_code;
        break;
      end
      @(negedge clkin);
    end
    check_eq("done_seen", {31'd0, seen}, 32'd1);
    check_eq("err_flag", {31'd0, e}, {31'd0, (exp_code != 3'd0)});
    check_eq("err_code", {29'd0, c}, {29'd0, exp_code});
    @(negedge clkin);
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);
    check_eq("err_held", {31'd0, err}, {31'd0, (exp_code != 3'd0)});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clkin);
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_wren", {31'd0, epcq_wren}, 32'd0);
    check_eq("rst_bulk", {31'd0, epcq_bulk_erase}, 32'd0);
    check_eq("rst_addr", {8'd0, epcq_addr}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 256; i++) begin
      @(negedge clkin);
      buf_wr_en = 1'b1; buf_wr_addr = 8'(i); buf_wr_data = 8'(i) ^ 8'hA5;
    end
    @(negedge clkin) buf_wr_en = 1'b0;

    // 1: sector erase; len is ignored for erase.
    run_cmd(2'b01, 24'h010000, 9'd0, 1'b0, 3'd0);
    check_eq("erase_pulses", n_erase, 32'd1);
    check_eq("erase_wren", n_wren, 32'd1);
    check_eq("erase_addr", {8'd0, erase_addr}, 32'h00010000);

    // 2: full-page program.
    run_cmd(2'b10, 24'h020000, 9'd256, 1'b0, 3'd0);
    check_eq("prog_shift_cycles", n_shift, 32'd256);
    check_eq("prog_data_errs", n_data_err, 32'd0);
    check_eq("prog_write_pulses", n_write, 32'd1);
    check_eq("prog_wren_cycles", n_wren, 32'd257);
    check_eq("prog_write_addr", {8'd0, write_addr}, 32'h00020000);

    // 3: page cross, flash must see nothing.
    run_cmd(2'b10, 24'h0200F0, 9'd32, 1'b0, 3'd2);
    check_eq("cross_strobes", n_wren + n_shift + n_write + n_erase + n_read + n_rden, 32'd0);

    // 4: read back 16 bytes.
    run_cmd(2'b11, 24'h020000, 9'd16, 1'b0, 3'd0);
    check_eq("read_pulses", n_read, 32'd1);
    check_eq("read_bytes", n_rdv, 32'd16);
    check_eq("read_data_errs", n_rd_err, 32'd0);
    check_eq("read_rden_after_last", {31'd0, rden_at_last}, 32'd0);

    // Bad op and length boundaries.
    run_cmd(2'b00, 24'h000000, 9'd1, 1'b0, 3'd1);
    run_cmd(2'b11, 24'h000000, 9'd0, 1'b0, 3'd1);
    run_cmd(2'b10, 24'h000000, 9'd257, 1'b0, 3'd1);

    // 5a: illegal write during busy; a buffer write outside IDLE must be ignored.
    m_illw = 1'b1;
    run_cmd(2'b10, 24'h030000, 9'd4, 1'b1, 3'd4);
    m_illw = 1'b0;
    check_eq("poke_ignored", {24'd0, first_shift}, 32'h000000A5);
    check_eq("illw_shift_cycles", n_shift, 32'd4);

    // 5b: busy stuck -> timeout, flash reset pulse.
    m_hang = 1'b1;
    run_cmd(2'b01, 24'h060000, 9'd0, 1'b0, 3'd5);
    m_hang = 1'b0;
    check_eq("timeout_reset_pulses", n_reset, 32'd1);

    // 6: reset in cycle 10 of SHIFT.
    clear_counts();
    send_cmd(2'b10, 24'h040000, 9'd256, 1'b0);
    begin
      bit shifting = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (epcq_shift_bytes) begin
          shifting = 1'b1;
          break;
        end
        @(negedge clkin);
      end
      check_eq("abort_shift_started", {31'd0, shifting}, 32'd1);
    end
    repeat (9) @(negedge clkin);
    reset_n = 1'b0;
    #1;
    check_eq("abort_shift", {31'd0, epcq_shift_bytes}, 32'd0);
    check_eq("abort_wren", {31'd0, epcq_wren}, 32'd0);
    check_eq("abort_datain", {24'd0, epcq_datain}, 32'd0);
    check_eq("abort_addr", {8'd0, epcq_addr}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clkin);
    reset_n = 1'b1;
    @(negedge clkin);
    check_eq("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
    repeat (30) @(negedge clkin);
    check_eq("abort_no_done", n_done, 32'd0);
    run_cmd(2'b01, 24'h050000, 9'd0, 1'b0, 3'd0);
    check_eq("post_abort_erase", n_erase, 32'd1);
    check_eq("post_abort_erase_addr", {8'd0, erase_addr}, 32'h00050000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
